puf_collect: RTL and testbench
==============================

PUF_COLLECT -- requirements
Module: puf_collect

Interface
REQ-001 SHALL have parameter W, default 16, meaning PUF word and challenge width in bits (legal values 8, 16, 32).
REQ-002 SHALL have parameter N_WORDS, default 8, meaning number of response words collected per run.
REQ-003 SHALL have parameter VOTES, default 3, meaning samples per word for the majority vote (odd, 1..15).
REQ-004 SHALL have parameter SETTLE, default 2, meaning idle cycles with a stable challenge before each sample (0..15).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port start, input, 1 bit: begin a run; sampled in IDLE or DONE only.
REQ-008 SHALL have port seed, input, W bits: initial LFSR challenge, captured on an accepted start.
REQ-009 SHALL have port chal, output, W bits: challenge driven to the external PUF.
REQ-010 SHALL have port resp, input, W bits: PUF response to chal.
REQ-011 SHALL have port puf_out, output, W*N_WORDS bits: collected, voted response.
REQ-012 SHALL have port busy, output, 1 bit: high while a run is in progress.
REQ-013 SHALL have port puf_done, output, 1 bit: level, high from run completion until the next accepted start or reset.
REQ-014 SHALL have port unstable_cnt, output, clog2(W*N_WORDS+1) bits: number of bits in the run whose samples were not unanimous.

Function
REQ-015 SHALL implement states IDLE, LOAD, SETTLE, SAMPLE, VOTE, STEP, DONE.
REQ-016 SHALL move IDLE/DONE -> LOAD on start, clearing puf_done and unstable_cnt and capturing seed; start is ignored in all other states.
REQ-017 SHALL in LOAD drive chal = seed, or all-ones if seed == 0 (LFSR lock-up guard), then go to SETTLE.
REQ-018 SHALL hold SETTLE for exactly SETTLE cycles (skipped when 0), then go to SAMPLE.
REQ-019 SHALL in SAMPLE add each resp bit to a per-bit ones counter; after fewer than VOTES samples return to SETTLE, otherwise go to VOTE.
REQ-020 SHALL in VOTE write bit b of word i as (ones[b] > VOTES/2), clear the counters, and add the count of bits with 0 < ones[b] < VOTES to unstable_cnt.
REQ-021 SHALL place word i in puf_out[W*(N_WORDS-i)-1 -: W], so word 0 occupies the MSBs.
REQ-022 SHALL go VOTE -> STEP if i < N_WORDS-1, else VOTE -> DONE; STEP advances chal one LFSR step, increments i, and goes to SETTLE.
REQ-023 SHALL keep chal constant outside LOAD and STEP.
REQ-024 SHALL keep busy high for exactly T = 1 + N_WORDS*(VOTES*(SETTLE+1)+1) + (N_WORDS-1) cycles, which is 88 for the defaults; puf_done SHALL rise on the edge at which busy falls.
REQ-025 SHALL leave puf_out slices not yet rewritten in a run holding their previous values.
REQ-026 SHALL saturate unstable_cnt at its maximum value, which cannot be exceeded by construction.

Reset
REQ-027 SHALL on rst asserted, at any time including mid-run, force state IDLE, chal = 0, puf_out = 0, busy = 0, puf_done = 0, unstable_cnt = 0, and clear the counters and word index.

Structure
REQ-028 SHALL take the state enum and the Fibonacci LFSR tap constants from shared package puf_pkg: W=8 x^8+x^6+x^5+x^4+1; W=16 x^16+x^14+x^13+x^11+1; W=32 x^32+x^22+x^2+x^1+1.
REQ-029 SHALL instantiate one sub-module, puf_lfsr (parametrised W, with load, step and state output), for challenge generation.

Verification
REQ-030 Defaults, PUF stub resp = chal ^ 16'hA5A5, seed 16'h1234 -> puf_out[127:112] = 16'hB791, busy high 88 cycles, puf_done level high, unstable_cnt = 0.
REQ-031 Same stub with resp bit 0 flipped on the 2nd sample of word 0 only -> puf_out unchanged from REQ-030, unstable_cnt = 1.
REQ-032 seed = 0 -> first chal = 16'hFFFF, puf_out[127:112] = 16'h5A5A.
REQ-033 start pulsed at busy-cycle 20 -> ignored; completion still at cycle 88 with identical puf_out.
REQ-034 rst asserted at busy-cycle 40 -> all outputs 0 immediately; a new start afterwards completes in 88 cycles with the correct result.
REQ-035 start asserted in DONE -> puf_done drops the next cycle, the rerun yields identical puf_out, and puf_out holds steady after done.

Source files
------------

// File: rtl/puf_pkg.sv
// Shared types and constants for the PUF response collector: FSM states and
// Fibonacci LFSR feedback masks for the supported challenge widths.
package puf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_SETTLE, ST_SAMPLE, ST_VOTE, ST_STEP, ST_DONE
  } state_t;

  // Bit k set means x^(k+1) is a feedback term.
  localparam logic [31:0] TAPS8  = 32'h0000_00B8;  // x^8+x^6+x^5+x^4+1
  localparam logic [31:0] TAPS16 = 32'h0000_B400;  // x^16+x^14+x^13+x^11+1
  localparam logic [31:0] TAPS32 = 32'h8020_0003;  // x^32+x^22+x^2+x^1+1

  function automatic logic [31:0] lfsr_taps(input int w);
    case (w)
      8:       return TAPS8;
      32:      return TAPS32;
      default: return TAPS16;
    endcase
  endfunction

endpackage

// File: rtl/puf_lfsr.sv
// Fibonacci LFSR producing the PUF challenge; shifts left, feedback into bit 0.
module puf_lfsr
  import puf_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] din,
  output logic [W-1:0] state
);

  localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       state <= '0;
    else if (load) state <= din;
    else if (step) state <= {state[W-2:0], ^(state & TAPS)};
  end

endmodule

// File: rtl/puf_collect.sv
// PUF response collector: drives LFSR challenges, majority-votes VOTES samples
// per word and packs N_WORDS voted words (word 0 in the MSBs) into puf_out.
module puf_collect
  import puf_pkg::*;
#(
  parameter int W       = 16,
  parameter int N_WORDS = 8,
  parameter int VOTES   = 3,
  parameter int SETTLE  = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [W-1:0]                       seed,
  output logic [W-1:0]                       chal,
  input  logic [W-1:0]                       resp,
  output logic [W*N_WORDS-1:0]               puf_out,
  output logic                               busy,
  output logic                               puf_done,
  output logic [$clog2(W*N_WORDS+1)-1:0]     unstable_cnt
);

  localparam int CW = $clog2(VOTES+1);
  localparam int UW = $clog2(W*N_WORDS+1);
  localparam int IW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [CW-1:0] HALF = CW'(VOTES/2);
  localparam logic [CW-1:0] ALL  = CW'(VOTES);
  localparam logic [UW:0]   UMAX = {1'b0, {UW{1'b1}}};
  // A zero SETTLE skips the settle state entirely.
  localparam state_t AFTER = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

  state_t              state, nxt;
  logic [3:0]          settle_cnt, samp_cnt;
  logic [IW-1:0]       idx;
  logic [W-1:0][CW-1:0] ones;
  logic                load, step, settle_done, last_samp, last_word;
  logic [W-1:0]        word, lfsr_din;
  logic [UW-1:0]       unst_add;
  logic [UW:0]         unst_sum;

  assign settle_done = settle_cnt == 4'(SETTLE-1);
  assign last_samp   = samp_cnt == 4'(VOTES-1);
  assign last_word   = idx == IW'(N_WORDS-1);
  assign lfsr_din    = (seed == '0) ? '1 : seed;  // all-zero would lock the LFSR
  assign busy        = (state != ST_IDLE) && (state != ST_DONE);
  assign puf_done    = state == ST_DONE;

  puf_lfsr #(.W(W)) u_lfsr (
    .clk(clk), .rst(rst), .load(load), .step(step), .din(lfsr_din), .state(chal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt  = state;
    load = 1'b0;
    step = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: if (start) begin nxt = ST_LOAD; load = 1'b1; end
      ST_LOAD:   nxt = AFTER;
      ST_SETTLE: if (settle_done) nxt = ST_SAMPLE;
      ST_SAMPLE: nxt = last_samp ? ST_VOTE : AFTER;
      ST_VOTE:   nxt = last_word ? ST_DONE : ST_STEP;
      ST_STEP:   begin step = 1'b1; nxt = AFTER; end
      default:   nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    word     = '0;
    unst_add = '0;
    for (int b = 0; b < W; b++) begin
      word[b] = ones[b] > HALF;
      if (ones[b] != '0 && ones[b] != ALL) unst_add = unst_add + UW'(1);
    end
    unst_sum = {1'b0, unstable_cnt} + {1'b0, unst_add};
    if (unst_sum > UMAX) unst_sum = UMAX;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_cnt   <= '0;
      samp_cnt     <= '0;
      idx          <= '0;
      ones         <= '0;
      puf_out      <= '0;
      unstable_cnt <= '0;
    end else begin
      if (load) begin
        settle_cnt   <= '0;
        samp_cnt     <= '0;
        idx          <= '0;
        ones         <= '0;
        unstable_cnt <= '0;
      end
      if (state == ST_SETTLE) settle_cnt <= settle_done ? 4'd0 : settle_cnt + 4'd1;
      if (state == ST_SAMPLE) begin
        for (int b = 0; b < W; b++) ones[b] <= ones[b] + CW'(resp[b]);
        samp_cnt <= last_samp ? 4'd0 : samp_cnt + 4'd1;
      end
      if (state == ST_VOTE) begin
        for (int k = 0; k < N_WORDS; k++)
          if (idx == IW'(k)) puf_out[W*(N_WORDS-k)-1 -: W] <= word;
        ones         <= '0;
        unstable_cnt <= unst_sum[UW-1:0];
      end
      if (state == ST_STEP) idx <= idx + IW'(1);
    end
  end

endmodule

// File: tb/tb_puf_collect.sv
// Directed bench for puf_collect: stimulus pushes expected run results, a
// monitor pops and checks them whenever puf_done rises.
module tb_puf_collect;

  localparam logic [15:0] MASK = 16'hA5A5;

  logic         clk = 0, rst = 1, start = 0, flip = 0;
  logic [15:0]  seed = '0, chal, resp;
  logic [127:0] puf_out;
  logic         busy, puf_done;
  logic [7:0]   unstable_cnt;

  typedef struct { logic [127:0] out; logic [7:0] unst; int len; } exp_t;
  exp_t q[$];
  int total = 0, bad = 0;

  puf_collect dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .chal(chal), .resp(resp),
    .puf_out(puf_out), .busy(busy), .puf_done(puf_done), .unstable_cnt(unstable_cnt)
  );

  always #5 clk = ~clk;
  always_comb resp = chal ^ MASK ^ {15'b0, flip};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Reference: x^16+x^14+x^13+x^11+1, shift left, feedback into bit 0.
  function automatic logic [127:0] model(input logic [15:0] s0);
    logic [15:0] s;
    logic [127:0] o;
    logic fb;
    s = (s0 == 16'h0) ? 16'hFFFF : s0;
    o = '0;
    for (int i = 0; i < 8; i++) begin
      o[16*(8-i)-1 -: 16] = s ^ MASK;
      fb = s[15] ^ s[13] ^ s[12] ^ s[10];
      s = {s[14:0], fb};
    end
    return o;
  endfunction

  task automatic push(input logic [15:0] s, input logic [7:0] u);
    exp_t e;
    e.out = model(s); e.unst = u; e.len = 88;
    q.push_back(e);
  endtask

  task automatic do_start(input logic [15:0] s);
    @(posedge clk); #1 start = 1; seed = s;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!puf_done && n < 300) begin @(posedge clk); #1; n++; end
    if (!puf_done) begin
      total++; bad++;
      $display("FAIL %s: timeout got done=%0b want 1", name, puf_done);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor
  int   blen = 0;
  logic pbusy = 0, pdone = 0;
  always @(negedge clk) begin
    exp_t e;
    if (busy && !pbusy) blen = 1;
    else if (busy) blen++;
    if (puf_done && !pdone) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: got done=1 want no completion");
      end else begin
        e = q.pop_front();
        chk("run_puf_out", puf_out, e.out);
        chk("run_unstable", 128'(unstable_cnt), 128'(e.unst));
        chk("run_busy_len", 128'(blen), 128'(e.len));
      end
    end
    pbusy = busy;
    pdone = puf_done;
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_chal", 128'(chal), 128'h0);
    chk("rst_puf_out", puf_out, 128'h0);
    chk("rst_busy", 128'(busy), 128'h0);
    chk("rst_done", 128'(puf_done), 128'h0);
    chk("rst_unstable", 128'(unstable_cnt), 128'h0);
    rst = 0;

    // Clean run
    push(16'h1234, 8'd0);
    do_start(16'h1234);
    wait_done("clean");
    chk("clean_word0", 128'(puf_out[127:112]), 128'(16'hB791));
    repeat (5) @(posedge clk);
    #1 chk("done_level", 128'(puf_done), 128'h1);

    // Bit 0 flipped on the second sample of word 0 (busy-cycle 6)
    push(16'h1234, 8'd1);
    do_start(16'h1234);
    repeat (6) @(posedge clk);
    #1 flip = 1;
    @(posedge clk); #1 flip = 0;
    wait_done("flip");

    // Zero seed guard
    push(16'h0000, 8'd0);
    do_start(16'h0000);
    chk("zero_first_chal", 128'(chal), 128'(16'hFFFF));
    chk("zero_busy", 128'(busy), 128'h1);
    wait_done("zero");
    chk("zero_word0", 128'(puf_out[127:112]), 128'(16'h5A5A));

    // Start mid-run is ignored
    push(16'h1234, 8'd0);
    do_start(16'h1234);
    repeat (20) @(posedge clk);
    #1 start = 1; seed = 16'h5555;
    @(posedge clk); #1 start = 0;
    wait_done("midstart");

    // Reset mid-run
    do_start(16'h1234);
    repeat (40) @(posedge clk);
    #1 rst = 1;
    #1;
    chk("midrst_chal", 128'(chal), 128'h0);
    chk("midrst_puf_out", puf_out, 128'h0);
    chk("midrst_busy", 128'(busy), 128'h0);
    chk("midrst_done", 128'(puf_done), 128'h0);
    chk("midrst_unstable", 128'(unstable_cnt), 128'h0);
    @(posedge clk); #1 rst = 0;
    push(16'hBEEF, 8'd0);
    do_start(16'hBEEF);
    wait_done("after_rst");

    // Restart from DONE
    push(16'hBEEF, 8'd0);
    do_start(16'hBEEF);
    chk("redo_done_drop", 128'(puf_done), 128'h0);
    wait_done("redo");
    repeat (6) @(posedge clk);
    #1 chk("redo_hold", puf_out, model(16'hBEEF));

    repeat (2) @(posedge clk);
    chk("queue_empty", 128'(q.size()), 128'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
